ddr_ctl1_issuer: RTL and testbench
==================================

DDR_CTL1_ISSUER -- requirements
Module: ddr_ctl1_issuer

Interface
REQ-001 SHALL have parameter OP_NOP, default 4'h0, NOP opcode.
REQ-002 SHALL have parameters OP_LA0..OP_LA3, defaults 4'h1..4'h4, load address byte n = addr[8n+7:8n].
REQ-003 SHALL have parameters OP_LD0..OP_LD3, defaults 4'h5..4'h8, load data byte n = data[8n+7:8n].
REQ-004 SHALL have parameters OP_RDP (4'h9) and OP_WRP (4'hA): read page, write page.
REQ-005 clock  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low (0 = reset).
REQ-007 req_valid  in  1  host request present.
REQ-008 req_ready  out  1  issuer accepts request this cycle.
REQ-009 req_write  in  1  1 = write page, 0 = read page.
REQ-010 req_addr  in  32  page address.
REQ-011 req_data  in  32  write data (ignored on read).
REQ-012 rsp_valid  out  1  one-cycle pulse: read data valid.
REQ-013 rsp_data  out  32  read result, held until next read completes.
REQ-014 ctl_inst  out  12  {opcode[3:0], imm[7:0]} to controller.
REQ-015 ctl_inst_en  out  1  ctl_inst valid this cycle.
REQ-016 ctl_page  in  32  page read back from controller.
REQ-017 ctl_ready  in  1  controller idle, able to take instructions.

Function
REQ-018 States SHALL be IDLE, ADDR, DATA, CMD, WAIT_BUSY, WAIT_DONE; 2-bit byte index n.
REQ-019 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready; on accept, latch write/addr/data, n<=0, go ADDR.
REQ-020 Shadow regs sh_addr[31:0], sh_data[31:0], with per-byte valid bits, all invalid after reset.
REQ-021 ADDR: byte n emitted (LAn, imm = addr byte n) only if shadow byte invalid or differs; unchanged bytes skipped at zero cost, one byte per cycle considered.
REQ-022 After byte 3 in ADDR: write -> DATA (n<=0); read -> CMD.
REQ-023 DATA: same skip rule as REQ-021 using LDn and sh_data; after byte 3 -> CMD.
REQ-024 An instruction SHALL be emitted (ctl_inst_en=1) only in a cycle where ctl_ready=1; otherwise the state and n stall, ctl_inst_en=0.
REQ-025 On emitting LAn/LDn, the matching shadow byte SHALL be updated and marked valid the same edge.
REQ-026 CMD: emit WRP or RDP (imm = 8'h00), go WAIT_BUSY.
REQ-027 WAIT_BUSY: wait for ctl_ready=0, then WAIT_DONE; WAIT_DONE: wait for ctl_ready=1, then IDLE.
REQ-028 On WAIT_DONE exit after RDP: rsp_data<=ctl_page and rsp_valid=1 for exactly that one cycle; no pulse after WRP.
REQ-029 RDP SHALL invalidate all sh_data valid bits (controller data register overwritten by read).
REQ-030 When ctl_inst_en=0, ctl_inst SHALL be {OP_NOP, 8'h00}.
REQ-031 Minimum issue latency, all bytes changed, ctl_ready held 1: write = 9 instruction cycles (LA0..3, LD0..3, WRP); read = 5 (LA0..3, RDP); fully cached address = WRP/RDP in the cycle after the accept cycle.
REQ-032 req_valid asserted outside IDLE SHALL be ignored; request fields not sampled after accept.

Reset
REQ-033 reset=0 at a clock edge SHALL, from any state including mid-sequence, force IDLE, n=0, all shadow valid bits=0.
REQ-034 Reset outputs: req_ready=0 while reset=0, then 1 in first IDLE cycle; ctl_inst_en=0, ctl_inst={OP_NOP,8'h00}, rsp_valid=0, rsp_data=32'h0.

Verification
REQ-035 After reset, write addr 32'h0000_0000 data 32'hDDCC_BBAA, ctl_ready=1 -> LA0..LA3 imm 00, LD0..LD3 imm AA,BB,CC,DD, WRP on 9 consecutive cycles.
REQ-036 Then write addr 32'h0100_0000 data 32'h2211_FFEE -> only LA3 imm 01, LD0..LD3 EE,FF,11,22, WRP.
REQ-037 Read addr 32'h0100_0000, model drops ctl_ready 2 cycles after RDP for 300 cycles with ctl_page=32'hEFEF_EFEF -> only RDP issued; rsp_valid single pulse, rsp_data=32'hEFEF_EFEF.
REQ-038 ctl_ready=0 mid-ADDR sequence for 5 cycles -> no ctl_inst_en, sequence resumes at same byte, no byte duplicated or lost.
REQ-039 reset=0 during DATA of a write -> next write with identical addr/data re-emits all 4 LA and 4 LD bytes.
REQ-040 req_valid held during WAIT_DONE -> req_ready=0, request accepted only in IDLE cycle after completion.

Source files
------------

// File: rtl/ddr_ctl1_issuer.sv
// Host-to-controller instruction issuer. Breaks a page read/write request into
// byte-load instructions followed by RDP/WRP. A shadow copy of the controller's
// address and data registers lets bytes the controller already holds be skipped.
module ddr_ctl1_issuer #(
  parameter logic [3:0] OP_NOP = 4'h0,
  parameter logic [3:0] OP_LA0 = 4'h1,
  parameter logic [3:0] OP_LA1 = 4'h2,
  parameter logic [3:0] OP_LA2 = 4'h3,
  parameter logic [3:0] OP_LA3 = 4'h4,
  parameter logic [3:0] OP_LD0 = 4'h5,
  parameter logic [3:0] OP_LD1 = 4'h6,
  parameter logic [3:0] OP_LD2 = 4'h7,
  parameter logic [3:0] OP_LD3 = 4'h8,
  parameter logic [3:0] OP_RDP = 4'h9,
  parameter logic [3:0] OP_WRP = 4'hA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [11:0] ctl_inst,
  output logic        ctl_inst_en,
  input  logic [31:0] ctl_page,
  input  logic        ctl_ready
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] CMD       = 3'd3;
  localparam logic [2:0] WAIT_BUSY = 3'd4;
  localparam logic [2:0] WAIT_DONE = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [1:0]  n_q, n_d;
  logic        wr_q;
  logic [31:0] addr_q, data_q;
  logic [31:0] sh_addr_q, sh_data_q;
  logic [3:0]  sh_addr_vld_q, sh_data_vld_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;

  // Sequence position: 0..3 address bytes, 4..7 data bytes, 8 page command.
  logic [3:0]  pos, sel, nxt;
  logic [8:0]  need;
  logic        issuing;
  logic [3:0]  op;
  logic [7:0]  imm;

  assign req_ready   = (state_q == IDLE) & reset;
  assign issuing     = ((state_q == ADDR) | (state_q == DATA) | (state_q == CMD)) & ctl_ready;
  assign ctl_inst_en = issuing & reset;
  assign ctl_inst    = ctl_inst_en ? {op, imm} : {OP_NOP, 8'h00};
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign nxt         = sel + 4'd1;

  // Pick the first position at or after the current one that must be issued;
  // cached bytes are skipped within the same cycle.
  always_comb begin
    pos = 4'd8;
    if (state_q == ADDR) pos = {2'b00, n_q};
    else if (state_q == DATA) pos = {2'b01, n_q};
    for (int i = 0; i < 4; i++) begin
      need[i]   = ~sh_addr_vld_q[i] | (sh_addr_q[8*i +: 8] != addr_q[8*i +: 8]);
      need[i+4] = wr_q & (~sh_data_vld_q[i] | (sh_data_q[8*i +: 8] != data_q[8*i +: 8]));
    end
    need[8] = 1'b1;
    sel = 4'd8;
    for (int i = 8; i >= 0; i--) begin
      if (need[i] && (4'(i) >= pos)) sel = 4'(i);
    end
  end

  // Opcode and immediate for the selected position.
  always_comb begin
    op  = OP_NOP;
    imm = 8'h00;
    unique case (sel)
      4'd0: op = OP_LA0;
      4'd1: op = OP_LA1;
      4'd2: op = OP_LA2;
      4'd3: op = OP_LA3;
      4'd4: op = OP_LD0;
      4'd5: op = OP_LD1;
      4'd6: op = OP_LD2;
      4'd7: op = OP_LD3;
      default: op = wr_q ? OP_WRP : OP_RDP;
    endcase
    if (sel < 4'd4) imm = addr_q[{sel[1:0], 3'b000} +: 8];
    else if (sel < 4'd8) imm = data_q[{sel[1:0], 3'b000} +: 8];
  end

  // Next-state logic; the emitting states hold while the controller is busy.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ADDR;
          n_d     = 2'd0;
        end
      end
      ADDR, DATA, CMD: begin
        if (ctl_ready) begin
          n_d = nxt[1:0];
          if (sel == 4'd8) state_d = WAIT_BUSY;
          else if (nxt < 4'd4) state_d = ADDR;
          else if (nxt < 4'd8) state_d = DATA;
          else state_d = CMD;
        end
      end
      WAIT_BUSY: if (!ctl_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (ctl_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State, request latch, shadow registers and read response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      n_q           <= 2'd0;
      wr_q          <= 1'b0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      sh_addr_q     <= 32'h0;
      sh_data_q     <= 32'h0;
      sh_addr_vld_q <= 4'h0;
      sh_data_vld_q <= 4'h0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      rsp_valid_q <= 1'b0;
      if (req_ready && req_valid) begin
        wr_q   <= req_write;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      if (issuing) begin
        if (sel < 4'd4) begin
          sh_addr_q[{sel[1:0], 3'b000} +: 8] <= addr_q[{sel[1:0], 3'b000} +: 8];
          sh_addr_vld_q[sel[1:0]]            <= 1'b1;
        end else if (sel < 4'd8) begin
          sh_data_q[{sel[1:0], 3'b000} +: 8] <= data_q[{sel[1:0], 3'b000} +: 8];
          sh_data_vld_q[sel[1:0]]            <= 1'b1;
        end else if (!wr_q) begin
          // A page read overwrites the controller's data register.
          sh_data_vld_q <= 4'h0;
        end
      end
      if ((state_q == WAIT_DONE) && ctl_ready && !wr_q) begin
        rsp_data_q  <= ctl_page;
        rsp_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_ctl1_issuer.sv
// Directed bench for ddr_ctl1_issuer with a small controller model that
// drops ctl_ready a few cycles after each page command.
module tb_ddr_ctl1_issuer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [11:0] ctl_inst;
  logic        ctl_inst_en;
  logic [31:0] ctl_page = 32'h0;
  logic        ctl_ready;

  logic        model_ready = 1'b1;
  logic        force_stall = 1'b0;
  logic        pending = 1'b0;
  int          delay = 0;
  int          busy = 0;
  int          busy_len = 3;

  int          cyc = 0;
  int          acc_cyc = 0;
  int          rsp_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [11:0] log_q[$];
  int          logc_q[$];
  logic [11:0] exp_q[$];

  assign ctl_ready = model_ready & ~force_stall;

  ddr_ctl1_issuer dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ctl_inst    (ctl_inst),
    .ctl_inst_en (ctl_inst_en),
    .ctl_page    (ctl_page),
    .ctl_ready   (ctl_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: log emitted instructions and response pulses mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (ctl_inst_en) begin
        log_q.push_back(ctl_inst);
        logc_q.push_back(cyc);
        if (ctl_inst[11:8] == 4'h9 || ctl_inst[11:8] == 4'hA) pending = 1'b1;
      end
      if (rsp_valid) rsp_cnt++;
    end
  end

  // Controller model: busy for busy_len cycles starting two cycles after a page command.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (busy > 0) begin
        busy--;
        if (busy == 0) model_ready = 1'b1;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          model_ready = 1'b0;
          busy = busy_len;
        end
      end
      if (pending) begin
        pending = 1'b0;
        delay = 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s count", tag), 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) check($sformatf("%s inst%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    logc_q.delete();
    rsp_cnt = 0;
  endtask

  // Present a request until accepted; fields are scrambled afterwards.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!ok) check("accept timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 32'hDEAD_BEEF;
    req_data  = 32'hBAAD_CAFE;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clock);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) check("idle timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int idle_cyc;
    bit ok;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst ctl_inst_en", 32'(ctl_inst_en), 32'd0);
    check("rst ctl_inst", 32'(ctl_inst), 32'h000);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", rsp_data, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("first idle req_ready", 32'(req_ready), 32'd1);

    // Cold write: every byte issued, 9 consecutive cycles
    clear_log();
    do_req(1'b1, 32'h0000_0000, 32'hDDCC_BBAA);
    wait_idle();
    exp_q = {12'h100, 12'h200, 12'h300, 12'h400, 12'h5AA, 12'h6BB, 12'h7CC, 12'h8DD, 12'hA00};
    check_log("cold wr");
    if (log_q.size() == 9) begin
      check("cold wr first cyc", 32'(logc_q[0]), 32'(acc_cyc + 1));
      check("cold wr last cyc", 32'(logc_q[8]), 32'(acc_cyc + 9));
    end
    check("cold wr no rsp", 32'(rsp_cnt), 32'd0);

    // Only the changed address byte is reloaded
    clear_log();
    do_req(1'b1, 32'h0100_0000, 32'h2211_FFEE);
    wait_idle();
    exp_q = {12'h401, 12'h5EE, 12'h6FF, 12'h711, 12'h822, 12'hA00};
    check_log("la3 wr");
    if (log_q.size() > 0) check("la3 wr first cyc", 32'(logc_q[0]), 32'(acc_cyc + 1));

    // Fully cached read with a long busy period
    busy_len = 300;
    ctl_page = 32'hEFEF_EFEF;
    clear_log();
    do_req(1'b0, 32'h0100_0000, 32'h0);
    wait_idle();
    @(negedge clock);
    exp_q = {12'h900};
    check_log("cached rd");
    if (log_q.size() > 0) check("cached rd cyc", 32'(logc_q[0]), 32'(acc_cyc + 1));
    check("cached rd pulses", 32'(rsp_cnt), 32'd1);
    check("cached rd data", rsp_data, 32'hEFEF_EFEF);
    busy_len = 3;

    // Read invalidated the data shadow: same write reloads all data bytes
    clear_log();
    do_req(1'b1, 32'h0100_0000, 32'h2211_FFEE);
    wait_idle();
    exp_q = {12'h5EE, 12'h6FF, 12'h711, 12'h822, 12'hA00};
    check_log("post rd wr");

    // Controller stall in the middle of the address bytes
    ctl_page = 32'h0BAD_F00D;
    clear_log();
    do_req(1'b0, 32'h1234_5678, 32'h0);
    @(posedge clock);
    #1;
    force_stall = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    force_stall = 1'b0;
    wait_idle();
    @(negedge clock);
    exp_q = {12'h178, 12'h256, 12'h334, 12'h412, 12'h900};
    check_log("stall rd");
    if (log_q.size() > 1) check("stall gap", 32'(logc_q[1] - logc_q[0]), 32'd6);
    check("stall rd data", rsp_data, 32'h0BAD_F00D);

    // Reset during the data bytes forgets all shadow state
    clear_log();
    do_req(1'b1, 32'hA1B2_C3D4, 32'h1122_3344);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid rst en", 32'(ctl_inst_en), 32'd0);
    check("mid rst logged", 32'(log_q.size()), 32'd5);
    @(posedge clock);
    #1;
    reset = 1'b1;
    clear_log();
    do_req(1'b1, 32'hA1B2_C3D4, 32'h1122_3344);
    wait_idle();
    exp_q = {12'h1D4, 12'h2C3, 12'h3B2, 12'h4A1, 12'h544, 12'h633, 12'h722, 12'h811, 12'hA00};
    check_log("post rst wr");

    // Request held through the wait states is taken only once idle
    ctl_page = 32'h5A5A_0001;
    clear_log();
    do_req(1'b1, 32'hA1B2_C3D4, 32'h1122_3344);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'hA1B2_C3D4;
    ok = 1'b0;
    idle_cyc = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        idle_cyc = cyc;
      end
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    wait_idle();
    @(negedge clock);
    check("held accepted", 32'(ok), 32'd1);
    check("held idle cyc", 32'(idle_cyc), 32'(acc_cyc + 8));
    exp_q = {12'hA00, 12'h900};
    check_log("held");
    if (log_q.size() == 2) check("held rdp cyc", 32'(logc_q[1]), 32'(idle_cyc + 1));
    check("held rsp pulses", 32'(rsp_cnt), 32'd1);
    check("held rsp data", rsp_data, 32'h5A5A_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
